// File: rtl/cgra_lv_pkg.sv
// Shared types for the loop-value update path: the op carried from the
// hloop strobes, the FSM state encoding, and the queued request record.
package cgra_lv_pkg;

   localparam int IDX_W = 5;

   typedef enum logic {
      OP_STEP = 1'b0,
      OP_INIT = 1'b1
   } lv_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      CALC = 2'd2,
      WR   = 2'd3
   } lv_st_t;

   typedef struct packed {
      lv_op_t           op;
      logic [IDX_W-1:0] idx;
   } lv_req_t;

   // Translate the active-low hloop strobe pair into the op to queue.
   // The result is only meaningful when the trigger is low.
   function automatic lv_op_t decode_op(input logic jmp_init);
      return jmp_init ? OP_STEP : OP_INIT;
   endfunction

endpackage

// File: rtl/lv_fifo.sv
// Small synchronous FIFO of pending loop-value requests. The head entry is
// visible combinationally on pop_data. A push is accepted while full as long
// as a pop happens in the same cycle.
module lv_fifo
   import cgra_lv_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic    Clk,
   input  logic    Reset,
   input  logic    push,
   input  lv_req_t push_data,
   input  logic    pop,
   output lv_req_t pop_data,
   output logic    full,
   output logic    empty
);

   localparam int PTR_W = $clog2(DEPTH);

   lv_req_t          mem [DEPTH];
   logic [PTR_W:0]   wr_ptr;
   logic [PTR_W:0]   rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
   assign do_pop   = pop && !empty;
   assign do_push  = push && (!full || do_pop);
   assign pop_data = mem[rd_ptr[PTR_W-1:0]];

   // Pointer update and storage write; the extra pointer bit separates full from empty.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr[PTR_W-1:0]] <= push_data;
            wr_ptr <= wr_ptr + (PTR_W+1)'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + (PTR_W+1)'(1);
         end
      end
   end

endmodule

// File: rtl/loop_val_upd.sv
// Loop-value updater: queues ops decoded from the hloop strobes and applies
// them one at a time to the CRF through its shared read/write port.
// INIT reloads the shadow init value; STEP does read, add stride, write back.
// A STEP therefore spends IDLE (pop), RD, CALC and WR in consecutive cycles.
module loop_val_upd
   import cgra_lv_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int NUM_LV   = 32,
   parameter int FIFO_DEP = 4
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              jmp_trigger,
   input  logic              jmp_init,
   input  logic [4:0]        jmp_index,
   input  logic              cfg_we,
   input  logic [4:0]        cfg_idx,
   input  logic [DATA_W-1:0] cfg_init,
   input  logic [DATA_W-1:0] cfg_stride,
   output logic              crf_rd_en,
   output logic [4:0]        crf_rd_addr,
   input  logic [DATA_W-1:0] crf_rd_data,
   output logic              crf_wr_req,
   output logic [4:0]        crf_wr_addr,
   output logic [DATA_W-1:0] crf_wr_data,
   input  logic              crf_wr_gnt,
   output logic              lv_busy,
   output logic              lv_ovf
);

   lv_st_t            state;
   lv_st_t            next_state;
   logic [DATA_W-1:0] init_tab   [NUM_LV];
   logic [DATA_W-1:0] stride_tab [NUM_LV];
   logic [4:0]        cur_idx;
   logic [DATA_W-1:0] wr_data_q;
   logic              push_req;
   lv_req_t           push_data;
   logic              fifo_pop;
   lv_req_t           fifo_head;
   logic              fifo_full;
   logic              fifo_empty;

   assign push_req     = !jmp_trigger;
   assign push_data.op  = decode_op(jmp_init);
   assign push_data.idx = jmp_index;

   lv_fifo #(
      .DEPTH(FIFO_DEP)
   ) u_fifo (
      .Clk      (Clk),
      .Reset    (Reset),
      .push     (push_req),
      .push_data(push_data),
      .pop      (fifo_pop),
      .pop_data (fifo_head),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   // Shadow init/stride tables; a write lands at the edge, so a same-cycle reader sees the old value.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         for (int i = 0; i < NUM_LV; i++) begin
            init_tab[i]   <= '0;
            stride_tab[i] <= '0;
         end
      end else if (cfg_we) begin
         init_tab[cfg_idx]   <= cfg_init;
         stride_tab[cfg_idx] <= cfg_stride;
      end
   end

   // Sticky overflow: a strobe arrived with the queue full and nothing leaving.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         lv_ovf <= 1'b0;
      end else if (push_req && fifo_full && !fifo_pop) begin
         lv_ovf <= 1'b1;
      end
   end

   // Next-state and port strobes; writes are only requested from WR.
   always_comb begin
      next_state = state;
      fifo_pop   = 1'b0;
      crf_rd_en  = 1'b0;
      crf_wr_req = 1'b0;
      case (state)
         IDLE: begin
            if (!fifo_empty) begin
               fifo_pop   = 1'b1;
               next_state = (fifo_head.op == OP_INIT) ? WR : RD;
            end
         end
         RD: begin
            crf_rd_en  = 1'b1;
            next_state = CALC;
         end
         CALC: begin
            next_state = WR;
         end
         WR: begin
            crf_wr_req = 1'b1;
            if (crf_wr_gnt) begin
               next_state = IDLE;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // State register plus the captured index and write data for the op in flight.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state     <= IDLE;
         cur_idx   <= '0;
         wr_data_q <= '0;
      end else begin
         state <= next_state;
         if (fifo_pop) begin
            cur_idx <= fifo_head.idx;
            if (fifo_head.op == OP_INIT) begin
               wr_data_q <= init_tab[fifo_head.idx];
            end
         end
         if (state == CALC) begin
            wr_data_q <= crf_rd_data + stride_tab[cur_idx];
         end
      end
   end

   assign crf_rd_addr = cur_idx;
   assign crf_wr_addr = cur_idx;
   assign crf_wr_data = wr_data_q;
   assign lv_busy     = !fifo_empty || (state != IDLE);

endmodule
